// File: rtl/cv32e40p_tmr_pkg.sv
// Shared types and constants for the triple-modular-redundant scrubbed register file.
package cv32e40p_tmr_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIX  = 2'd2
    } scrub_state_e;

endpackage

// File: rtl/cv32e40p_tmr_majority.sv
// Bitwise 2-of-3 majority voter.
module cv32e40p_tmr_majority #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] maj_o
);

    assign maj_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/cv32e40p_tmr_scrubber.sv
// Triplicated register file with a majority read port and a background scrubber
// that periodically sweeps every entry, counts disagreeing entries and rewrites
// them with the voted value.
// Optional fault-injection ports are enabled by defining CV32E40P_TMR_FAULT_INJ_EN.
module cv32e40p_tmr_scrubber
    import cv32e40p_tmr_pkg::*;
#(
    parameter int N_ENTRIES    = 16,
    parameter int WIDTH        = 32,
    parameter int SCRUB_PERIOD = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en_i,
    input  logic [$clog2(N_ENTRIES)-1:0]        wr_addr_i,
    input  logic [WIDTH-1:0]                    wr_data_i,
    input  logic [$clog2(N_ENTRIES)-1:0]        rd_addr_i,
    output logic [WIDTH-1:0]                    rd_data_o,
    output logic [N_ENTRIES-1:0][WIDTH-1:0]     rep0_o,
    output logic [N_ENTRIES-1:0][WIDTH-1:0]     rep1_o,
    output logic [N_ENTRIES-1:0][WIDTH-1:0]     rep2_o,
    input  logic                                scrub_en_i,
`ifdef CV32E40P_TMR_FAULT_INJ_EN
    input  logic                                inj_en_i,
    input  logic [1:0]                          inj_copy_i,
    input  logic [$clog2(N_ENTRIES)-1:0]        inj_addr_i,
    input  logic [WIDTH-1:0]                    inj_mask_i,
`endif
    output logic                                scrub_busy_o,
    output logic                                err_o,
    output logic                                done_o,
    output logic [ERR_CNT_W-1:0]                err_cnt_o
);

    localparam int AW = $clog2(N_ENTRIES);
    localparam int PW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(N_ENTRIES - 1);
    localparam logic [PW-1:0] LAST_PER = PW'(SCRUB_PERIOD - 1);

    // Three copies of the whole array, copy index outermost.
    logic [2:0][N_ENTRIES-1:0][WIDTH-1:0] rep_q, rep_d;

    scrub_state_e         state_q, state_d;
    logic [PW-1:0]        period_q, period_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [AW-1:0]        fix_idx_q, fix_idx_d;
    logic [WIDTH-1:0]     fix_data_q, fix_data_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0]     scan_maj;
    logic                 scan_mismatch;
    logic                 scan_wr_hit;
    logic                 fix_we;
    logic                 advance;

    cv32e40p_tmr_majority #(.WIDTH(WIDTH)) u_rd_vote (
        .a_i   (rep_q[0][rd_addr_i]),
        .b_i   (rep_q[1][rd_addr_i]),
        .c_i   (rep_q[2][rd_addr_i]),
        .maj_o (rd_data_o)
    );

    cv32e40p_tmr_majority #(.WIDTH(WIDTH)) u_scan_vote (
        .a_i   (rep_q[0][idx_q]),
        .b_i   (rep_q[1][idx_q]),
        .c_i   (rep_q[2][idx_q]),
        .maj_o (scan_maj)
    );

    assign scan_mismatch = (rep_q[0][idx_q] != scan_maj) ||
                           (rep_q[1][idx_q] != scan_maj) ||
                           (rep_q[2][idx_q] != scan_maj);

    // A functional write to the entry under inspection makes the detection stale.
    assign scan_wr_hit = wr_en_i && (wr_addr_i == idx_q);

    // The repair is dropped when the same entry is being rewritten functionally.
    assign fix_we = (state_q == FIX) && !(wr_en_i && (wr_addr_i == fix_idx_q));

    // Storage next state: injection first, then repair, then functional write (highest priority).
    always_comb begin
        rep_d = rep_q;
`ifdef CV32E40P_TMR_FAULT_INJ_EN
        if (inj_en_i) begin
            case (inj_copy_i)
                2'd0:    rep_d[0][inj_addr_i] = rep_q[0][inj_addr_i] ^ inj_mask_i;
                2'd1:    rep_d[1][inj_addr_i] = rep_q[1][inj_addr_i] ^ inj_mask_i;
                2'd2:    rep_d[2][inj_addr_i] = rep_q[2][inj_addr_i] ^ inj_mask_i;
                default: ;
            endcase
        end
`endif
        if (fix_we) begin
            for (int c = 0; c < 3; c++) rep_d[c][fix_idx_q] = fix_data_q;
        end
        if (wr_en_i) begin
            for (int c = 0; c < 3; c++) rep_d[c][wr_addr_i] = wr_data_i;
        end
    end

    // Scrubber FSM next state, pulses and error counter.
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        idx_d      = idx_q;
        fix_idx_d  = fix_idx_q;
        fix_data_d = fix_data_q;
        err_d      = 1'b0;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        advance    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!scrub_en_i) begin
                    period_d = '0;
                end else if (period_q == LAST_PER) begin
                    period_d = '0;
                    idx_d    = '0;
                    state_d  = SCAN;
                end else begin
                    period_d = period_q + PW'(1);
                end
            end
            SCAN: begin
                if (scan_mismatch && !scan_wr_hit) begin
                    fix_data_d = scan_maj;
                    fix_idx_d  = idx_q;
                    err_d      = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_W'(1);
                    state_d    = FIX;
                end else begin
                    advance = 1'b1;
                end
            end
            FIX:     advance = 1'b1;
            default: state_d = IDLE;
        endcase

        // Losing the enable finishes the current entry quietly; a full sweep reports done.
        if (advance) begin
            if (!scrub_en_i) begin
                idx_d   = '0;
                state_d = IDLE;
            end else if (idx_q == LAST_IDX) begin
                idx_d   = '0;
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                idx_d   = idx_q + AW'(1);
                state_d = SCAN;
            end
        end
    end

    // State and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q      <= '0;
            state_q    <= IDLE;
            period_q   <= '0;
            idx_q      <= '0;
            fix_idx_q  <= '0;
            fix_data_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rep_q      <= rep_d;
            state_q    <= state_d;
            period_q   <= period_d;
            idx_q      <= idx_d;
            fix_idx_q  <= fix_idx_d;
            fix_data_q <= fix_data_d;
            err_q      <= err_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rep0_o       = rep_q[0];
    assign rep1_o       = rep_q[1];
    assign rep2_o       = rep_q[2];
    assign scrub_busy_o = (state_q != IDLE);
    assign err_o        = err_q;
    assign done_o       = done_q;
    assign err_cnt_o    = cnt_q;

endmodule

// File: tb/tb_cv32e40p_tmr_scrubber.sv
// Directed bench for cv32e40p_tmr_scrubber: write/read table plus scrub corner sequences.
module tb_cv32e40p_tmr_scrubber;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int SP = 4;

    typedef logic [2:0][N-1:0][W-1:0] rep_t;

    typedef struct {
        logic         we;
        logic [2:0]   wa;
        logic [W-1:0] wd;
        logic [2:0]   ra;
        logic [W-1:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [W-1:0]     wr_data;
    logic [2:0]       rd_addr;
    logic [W-1:0]     rd_data;
    logic [N-1:0][W-1:0] rep0, rep1, rep2;
    logic             scrub_en;
    logic             busy, err, done;
    logic [15:0]      err_cnt;
`ifdef CV32E40P_TMR_FAULT_INJ_EN
    logic             inj_en;
    logic [1:0]       inj_copy;
    logic [2:0]       inj_addr;
    logic [W-1:0]     inj_mask;
`endif

    int   n_chk = 0;
    int   n_errs = 0;
    int   n_err_p = 0;
    int   n_done_p = 0;
    int   e0, d0;
    int   exp_cnt;
    rep_t frc_rep;
    vec_t vecs[8];

    cv32e40p_tmr_scrubber #(.N_ENTRIES(N), .WIDTH(W), .SCRUB_PERIOD(SP)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rep0_o       (rep0),
        .rep1_o       (rep1),
        .rep2_o       (rep2),
        .scrub_en_i   (scrub_en),
`ifdef CV32E40P_TMR_FAULT_INJ_EN
        .inj_en_i     (inj_en),
        .inj_copy_i   (inj_copy),
        .inj_addr_i   (inj_addr),
        .inj_mask_i   (inj_mask),
`endif
        .scrub_busy_o (busy),
        .err_o        (err),
        .done_o       (done),
        .err_cnt_o    (err_cnt)
    );

    always #5 clk = ~clk;

    // Pulse counters (each pulse is exactly one cycle wide).
    always @(posedge clk) begin
        if (err)  n_err_p++;
        if (done) n_done_p++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write(input logic [2:0] a, input logic [W-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Flip bits of one copy of one entry.
    task automatic corrupt(input int c, input int a, input logic [W-1:0] m);
`ifdef CV32E40P_TMR_FAULT_INJ_EN
        @(negedge clk);
        inj_en = 1'b1; inj_copy = 2'(c); inj_addr = 3'(a); inj_mask = m;
        @(negedge clk);
        inj_en = 1'b0;
`else
        @(negedge clk);
        frc_rep = dut.rep_q;
        frc_rep[c][a] = frc_rep[c][a] ^ m;
        force dut.rep_q = frc_rep;
        #1;
        release dut.rep_q;
        @(negedge clk);
`endif
    endtask

    // Enable scrubbing until done_o; optionally write wa/wd in the first FIX cycle.
    task automatic sweep(input bit wr_on_err, input logic [2:0] wa, input logic [W-1:0] wd);
        bit seen = 1'b0;
        bit wrote = 1'b0;
        @(negedge clk);
        scrub_en = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (done) seen = 1'b1;
            else if (wr_on_err && err && !wrote) begin
                wr_en = 1'b1; wr_addr = wa; wr_data = wd; wrote = 1'b1;
            end
        end
        scrub_en = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        chk("sweep_done_seen", W'(seen), 1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 3'd3, 32'hDEADBEEF, 3'd3, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 3'd0, 32'h12345678, 3'd3, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 3'd0, 32'h0,        3'd0, 32'h12345678};
        vecs[3] = '{1'b1, 3'd7, 32'hFFFFFFFF, 3'd7, 32'hFFFFFFFF};
        vecs[4] = '{1'b1, 3'd3, 32'h00000000, 3'd3, 32'h00000000};
        vecs[5] = '{1'b0, 3'd0, 32'h0,        3'd5, 32'h00000000};
        vecs[6] = '{1'b1, 3'd7, 32'hA5A5A5A5, 3'd7, 32'hA5A5A5A5};
        vecs[7] = '{1'b0, 3'd0, 32'h0,        3'd0, 32'h12345678};

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; scrub_en = 1'b0;
`ifdef CV32E40P_TMR_FAULT_INJ_EN
        inj_en = 1'b0; inj_copy = '0; inj_addr = '0; inj_mask = '0;
`endif
        exp_cnt = 0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", W'(busy), 0);
        chk("rst_err", W'(err), 0);
        chk("rst_done", W'(done), 0);
        chk("rst_rd", rd_data, 0);
        chk("rst_cnt", W'(err_cnt), 0);
        rst = 1'b0;

        // Reset in the middle of a sweep, then first-SCAN latency
        write(3'd2, 32'hCAFE0000);
        rd_addr = 3'd2;
        d0 = n_done_p;
        @(negedge clk);
        scrub_en = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", W'(busy), 1);
        chk("mid_rd", rd_data, 32'hCAFE0000);
        rst = 1'b1;
        #1;
        chk("abort_busy", W'(busy), 0);
        chk("abort_rep0", rep0[2], 0);
        chk("abort_rep2", rep2[2], 0);
        chk("abort_rd", rd_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("lat_idle3", W'(busy), 0);
        @(posedge clk);
        #1 chk("lat_scan4", W'(busy), 1);
        chk("abort_no_done", W'(n_done_p - d0), 0);
        sweep(1'b0, 3'd0, '0);
        chk("first_sweep_done", W'(n_done_p - d0), 1);

        // Write/read table, scrubber idle
        foreach (vecs[i]) begin
            @(negedge clk);
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd; rd_addr = vecs[i].ra;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp);
            chk($sformatf("vec%0d_rep0", i), rep0[vecs[i].ra], vecs[i].exp);
            chk($sformatf("vec%0d_rep1", i), rep1[vecs[i].ra], vecs[i].exp);
            chk($sformatf("vec%0d_rep2", i), rep2[vecs[i].ra], vecs[i].exp);
        end
        @(negedge clk);
        wr_en = 1'b0;

        // Single-bit fault in copy 1 of entry 5
        rd_addr = 3'd5;
        corrupt(1, 5, 32'h1);
        chk("inj5_rd", rd_data, 0);
        chk("inj5_rep1", rep1[5], 32'h1);
        e0 = n_err_p; d0 = n_done_p;
        sweep(1'b0, 3'd0, '0);
        exp_cnt = 1;
        chk("fix5_rep1", rep1[5], 0);
        chk("fix5_err_pulses", W'(n_err_p - e0), 1);
        chk("fix5_done_pulses", W'(n_done_p - d0), 1);
        chk("fix5_cnt", W'(err_cnt), W'(exp_cnt));

        // Disjoint faults in copies 0 and 2 of entry 2
        write(3'd2, 32'h0000FFFF);
        rd_addr = 3'd2;
        corrupt(0, 2, 32'h000000F0);
        corrupt(2, 2, 32'h0F000000);
        chk("inj2_rd", rd_data, 32'h0000FFFF);
        sweep(1'b0, 3'd0, '0);
        exp_cnt = 2;
        chk("fix2_rep0", rep0[2], 32'h0000FFFF);
        chk("fix2_rep2", rep2[2], 32'h0000FFFF);
        chk("fix2_cnt", W'(err_cnt), W'(exp_cnt));

        // Functional write to the entry being repaired wins
        corrupt(2, 7, 32'h000000FF);
        sweep(1'b1, 3'd7, 32'h00000055);
        exp_cnt = 3;
        chk("fixwr7_rep0", rep0[7], 32'h55);
        chk("fixwr7_rep1", rep1[7], 32'h55);
        chk("fixwr7_rep2", rep2[7], 32'h55);
        chk("fixwr7_cnt", W'(err_cnt), W'(exp_cnt));

        // Write to another entry during the repair cycle lands as well
        corrupt(0, 4, 32'h00000100);
        sweep(1'b1, 3'd6, 32'h00000066);
        exp_cnt = 4;
        chk("fixoth_rep0_4", rep0[4], 0);
        chk("fixoth_rep0_6", rep0[6], 32'h66);
        chk("fixoth_rep2_6", rep2[6], 32'h66);
        chk("fixoth_cnt", W'(err_cnt), W'(exp_cnt));

        // Write during SCAN of the faulty entry cancels the detection
        corrupt(0, 1, 32'h00000008);
        e0 = n_err_p; d0 = n_done_p;
        @(negedge clk);
        scrub_en = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("cancel_busy", W'(busy), 1);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h11;
        @(negedge clk);
        wr_en = 1'b0;
        sweep(1'b0, 3'd0, '0);
        chk("cancel_err_pulses", W'(n_err_p - e0), 0);
        chk("cancel_cnt", W'(err_cnt), W'(exp_cnt));
        chk("cancel_rep0", rep0[1], 32'h11);
        chk("cancel_done", W'(n_done_p - d0), 1);

        // Enable dropped while entry 3 is being scanned: repair completes, no done
        corrupt(1, 3, 32'h00000002);
        e0 = n_err_p; d0 = n_done_p;
        @(negedge clk);
        scrub_en = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        scrub_en = 1'b0;
        @(posedge clk);
        #1;
        chk("stop_fix_busy", W'(busy), 1);
        chk("stop_fix_err", W'(err), 1);
        @(posedge clk);
        #1 chk("stop_idle_busy", W'(busy), 0);
        repeat (3) @(negedge clk);
        exp_cnt = 5;
        chk("stop_no_done", W'(n_done_p - d0), 0);
        chk("stop_err_pulses", W'(n_err_p - e0), 1);
        chk("stop_cnt", W'(err_cnt), W'(exp_cnt));
        chk("stop_rep1", rep1[3], 0);

        // Counter saturation: preload near the top, then three faults
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        corrupt(0, 1, 32'h1);
        corrupt(2, 5, 32'h2);
        corrupt(1, 6, 32'h4);
        e0 = n_err_p;
        sweep(1'b0, 3'd0, '0);
        chk("sat_cnt", W'(err_cnt), 32'h0000FFFF);
        chk("sat_err_pulses", W'(n_err_p - e0), 3);
        chk("sat_rep2_5", rep2[5], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_errs);
        $finish;
    end

endmodule
